// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: a single request/done handshake on the host side and a
// three-state (IDLE -> SETUP -> ACCESS) sequencer on the SRAM side.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req, read      access request and operation select (0 = read, 1 = write)
//   addr, wdata    access address and write data, latched when req is accepted
//   ready          idle, able to accept req
//   done           one-cycle completion pulse for reads and writes
//   rdata          captured read data, held until the next read completes
//   Ram1Addr       SRAM address bus
//   Ram1Data       SRAM bidirectional data bus
//   Ram1EN/OE/WE   SRAM chip enable, output enable, write enable (all active-low)
module sram_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1EN,
  output logic              Ram1OE,
  output logic              Ram1WE
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic                r_op_wr, w_op_wr_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic                r_drive, w_drive_d;
  logic                r_en_n, w_en_n_d;
  logic                r_oe_n, w_oe_n_d;
  logic                r_we_n, w_we_n_d;
  logic                r_done, w_done_d;
  logic                r_ready, w_ready_d;
  logic [DATA_W-1:0]   r_rdata, w_rdata_d;

  // Every SRAM-facing signal is computed one cycle ahead and registered, so the pins
  // toggle cleanly off the clock edge with no combinational path from req.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_op_wr_d = r_op_wr;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_drive_d = r_drive;
    w_en_n_d  = r_en_n;
    w_oe_n_d  = r_oe_n;
    w_we_n_d  = r_we_n;
    w_done_d  = 1'b0;
    w_rdata_d = r_rdata;

    unique case (r_state)
      StIdle: begin
        w_en_n_d = 1'b1;
        w_oe_n_d = 1'b1;
        w_we_n_d = 1'b1;
        if (req) begin
          w_state_d = StSetup;
          w_op_wr_d = read;
          w_addr_d  = addr;
          w_wdata_d = wdata;
          // A following read releases the bus as its SETUP starts.
          w_drive_d = read;
          w_en_n_d  = 1'b0;
        end else begin
          // Write data stays on the bus through the done cycle, then releases.
          w_drive_d = 1'b0;
        end
      end
      StSetup: begin
        w_state_d = StAccess;
        w_cnt_d   = CntW'(WAIT_CYCLES);
        w_oe_n_d  = r_op_wr;
        w_we_n_d  = ~r_op_wr;
      end
      StAccess: begin
        w_cnt_d = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_d = StIdle;
          w_en_n_d  = 1'b1;
          w_oe_n_d  = 1'b1;
          w_we_n_d  = 1'b1;
          w_done_d  = 1'b1;
          if (!r_op_wr) begin
            w_rdata_d = Ram1Data;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_ready_d = (w_state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_drive <= 1'b0;
      r_en_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_op_wr <= w_op_wr_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_drive <= w_drive_d;
      r_en_n  <= w_en_n_d;
      r_oe_n  <= w_oe_n_d;
      r_we_n  <= w_we_n_d;
      r_done  <= w_done_d;
      r_ready <= w_ready_d;
      r_rdata <= w_rdata_d;
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign Ram1Addr = r_addr;
  assign Ram1EN   = r_en_n;
  assign Ram1OE   = r_oe_n;
  assign Ram1WE   = r_we_n;
  assign Ram1Data = r_drive ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two controllers (WAIT_CYCLES 1 and 3), each with a small SRAM model.
// Stimulus pushes expected completions into per-channel queues; a monitor pops and checks
// on every done pulse, and also checks strobe invariants every cycle.
module tb_sram_ctrl;
  localparam int AW = 18;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req = '0;
  logic [1:0]     rd  = '0;
  logic [AW-1:0]  addr_in  [2];
  logic [DW-1:0]  wdata_in [2];
  logic [1:0]     ready, done, en, oe, we;
  logic [DW-1:0]  rdata    [2];
  logic [AW-1:0]  ram_addr [2];
  wire  [DW-1:0]  bus0, bus1;
  logic [DW-1:0]  mem0 [256];
  logic [DW-1:0]  mem1 [256];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [1:0] prev_done = '0;

  typedef struct {
    bit          wr;
    logic [15:0] data;
    int          acc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .read(rd[0]), .addr(addr_in[0]),
    .wdata(wdata_in[0]), .ready(ready[0]), .done(done[0]), .rdata(rdata[0]),
    .Ram1Addr(ram_addr[0]), .Ram1Data(bus0), .Ram1EN(en[0]), .Ram1OE(oe[0]),
    .Ram1WE(we[0])
  );

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .read(rd[1]), .addr(addr_in[1]),
    .wdata(wdata_in[1]), .ready(ready[1]), .done(done[1]), .rdata(rdata[1]),
    .Ram1Addr(ram_addr[1]), .Ram1Data(bus1), .Ram1EN(en[1]), .Ram1OE(oe[1]),
    .Ram1WE(we[1])
  );

  // SRAM models: drive while selected with OE low, store while WE low.
  assign bus0 = (!en[0] && !oe[0]) ? mem0[ram_addr[0][7:0]] : 16'hzzzz;
  assign bus1 = (!en[1] && !oe[1]) ? mem1[ram_addr[1][7:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!en[0] && !we[0]) mem0[ram_addr[0][7:0]] <= bus0;
    if (rst) mem1[8'h12] <= 16'h1234;
    else if (!en[1] && !we[1]) mem1[ram_addr[1][7:0]] <= bus1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // An undriven bus reads as Z in 4-state simulation and as 0 in 2-state.
  function automatic bit released(input logic [DW-1:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  function automatic int wait_of(input int ch);
    return (ch == 0) ? 1 : 3;
  endfunction

  function automatic void push(input int ch, input bit wr, input logic [15:0] d);
    exp_t e;
    e.wr   = wr;
    e.data = d;
    e.acc  = cyc + 1;
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Monitor: invariants every cycle, scoreboard check on every done pulse.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      exp_t e;
      bit   have;
      check($sformatf("strobe_excl_ch%0d", ch), 32'(!oe[ch] && !we[ch]), 0);
      check($sformatf("strobe_frame_ch%0d", ch), 32'(en[ch] && (!oe[ch] || !we[ch])), 0);
      check($sformatf("done_double_ch%0d", ch), 32'(prev_done[ch] && done[ch]), 0);
      if (done[ch]) begin
        have = 1'b0;
        if (ch == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (ch == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done_ch%0d: done=1, expected 0 (t=%0t)", ch, $time);
        end else begin
          check($sformatf("latency_ch%0d", ch), 32'(cyc - e.acc), 32'(wait_of(ch) + 1));
          if (!e.wr) check($sformatf("rdata_ch%0d", ch), 32'(rdata[ch]), 32'(e.data));
        end
      end
      prev_done[ch] = done[ch];
    end
  end

  task automatic wait_ready(input int ch);
    int k = 0;
    while (!ready[ch] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("ready_timeout_ch%0d", ch), 32'(ready[ch]), 1);
  endtask

  // Called at a negedge; request is accepted on the following rising edge.
  task automatic issue(input int ch, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    wait_ready(ch);
    req[ch]      = 1'b1;
    rd[ch]       = wr;
    addr_in[ch]  = a;
    wdata_in[ch] = d;
    push(ch, wr, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int oe_low;
    int k;
    addr_in[0] = '0; addr_in[1] = '0;
    wdata_in[0] = '0; wdata_in[1] = '0;
    repeat (2) @(negedge clk);

    // Reset state on both controllers
    for (int ch = 0; ch < 2; ch++) begin
      check("rst_ready", 32'(ready[ch]), 1);
      check("rst_strobes", 32'({en[ch], oe[ch], we[ch]}), 32'h7);
      check("rst_done", 32'(done[ch]), 0);
      check("rst_addr", 32'(ram_addr[ch]), 0);
      check("rst_rdata", 32'(rdata[ch]), 0);
    end
    check("rst_bus0", 32'(released(bus0)), 1);
    rst = 1'b0;
    @(negedge clk);

    // Write, WAIT_CYCLES=1
    issue(0, 1'b1, 18'h00012, 16'hBEEF, 16'h0);
    @(negedge clk); req[0] = 1'b0;
    check("wr_setup_ready", 32'(ready[0]), 0);
    check("wr_setup_ctl", 32'({en[0], oe[0], we[0]}), 32'h3);
    check("wr_setup_bus", 32'(bus0), 32'hBEEF);
    check("wr_setup_addr", 32'(ram_addr[0]), 32'h12);
    @(negedge clk);
    check("wr_access_ctl", 32'({en[0], oe[0], we[0]}), 32'h2);
    check("wr_access_bus", 32'(bus0), 32'hBEEF);
    @(negedge clk);
    check("wr_done", 32'(done[0]), 1);
    check("wr_done_ctl", 32'({en[0], oe[0], we[0]}), 32'h7);
    check("wr_done_bus", 32'(bus0), 32'hBEEF);
    check("wr_done_addr", 32'(ram_addr[0]), 32'h12);
    @(negedge clk);
    check("wr_release", 32'(released(bus0)), 1);

    // Read, WAIT_CYCLES=3
    issue(1, 1'b0, 18'h00012, 16'h0, 16'h1234);
    @(negedge clk); req[1] = 1'b0;
    check("rd_setup_oe", 32'(oe[1]), 1);
    check("rd_setup_en", 32'(en[1]), 0);
    check("rd_setup_bus", 32'(released(bus1)), 1);
    oe_low = 0;
    repeat (5) begin
      @(negedge clk);
      if (!oe[1]) oe_low++;
    end
    check("rd_oe_cycles", 32'(oe_low), 3);

    // Back-to-back write then read, req held high
    issue(0, 1'b1, 18'h00001, 16'hA5A5, 16'h0);
    @(negedge clk);
    rd[0] = 1'b0;
    wdata_in[0] = 16'h0F0F;
    @(negedge clk);
    check("b2b_wr_access_we", 32'(we[0]), 0);
    check("b2b_wr_access_bus", 32'(bus0), 32'hA5A5);
    @(negedge clk);
    check("b2b_done_ready", 32'(ready[0]), 1);
    push(0, 1'b0, 16'hA5A5);
    @(negedge clk); req[0] = 1'b0;
    check("b2b_rd_setup_ready", 32'(ready[0]), 0);
    check("b2b_rd_setup_en", 32'(en[0]), 0);
    check("b2b_rd_setup_bus", 32'(released(bus0)), 1);
    repeat (4) @(negedge clk);

    // Reset in the middle of a write's ACCESS
    issue(0, 1'b1, 18'h00005, 16'h3C3C, 16'h0);
    @(negedge clk); req[0] = 1'b0;
    @(negedge clk);
    check("mid_access_we", 32'(we[0]), 0);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("mrst_ctl", 32'({en[0], oe[0], we[0]}), 32'h7);
    check("mrst_bus", 32'(released(bus0)), 1);
    check("mrst_ready", 32'(ready[0]), 1);
    check("mrst_done", 32'(done[0]), 0);
    check("mrst_addr", 32'(ram_addr[0]), 0);
    check("mrst_rdata", 32'(rdata[0]), 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 1'b0, 18'h00001, 16'h0, 16'hA5A5);
    @(negedge clk); req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Input churn while busy (WAIT_CYCLES=3)
    issue(1, 1'b1, 18'h00022, 16'h1357, 16'h0);
    @(negedge clk);
    k = 0;
    while (!ready[1] && k < 20) begin
      check("churn_addr", 32'(ram_addr[1]), 32'h22);
      check("churn_bus", 32'(bus1), 32'h1357);
      req[1]      = 1'($urandom);
      rd[1]       = 1'($urandom);
      addr_in[1]  = 18'($urandom);
      wdata_in[1] = 16'($urandom);
      @(negedge clk);
      k++;
    end
    req[1] = 1'b0;
    check("churn_done_addr", 32'(ram_addr[1]), 32'h22);
    check("churn_done_bus", 32'(bus1), 32'h1357);
    @(negedge clk);
    issue(1, 1'b0, 18'h00022, 16'h0, 16'h1357);
    @(negedge clk); req[1] = 1'b0;
    repeat (6) @(negedge clk);

    // rdata holds across a write and idle cycles
    issue(0, 1'b1, 18'h00007, 16'h1111, 16'h0);
    @(negedge clk); req[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("rdata_hold", 32'(rdata[0]), 32'hA5A5);

    repeat (10) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
